// File: rtl/tta_stream_fifo.sv
// Single-clock token FIFO between TTA stream ports and the downstream consumer.
// Read data is registered (non-show-ahead) so the storage array maps onto block RAM.
module tta_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstx,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wa, ra;

  // Flags come straight from the registered count; requests never reach them combinationally.
  assign full      = cnt_q[ADDR_WIDTH];
  assign empty     = (cnt_q == '0);
  assign usedw     = cnt_q[ADDR_WIDTH-1:0];
  assign q         = q_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wa          = wrreq & ~full;
    ra          = rdreq & ~empty;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    overflow_d  = wrreq & full;
    underflow_d = rdreq & empty;

    if (wa) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (ra) begin
      rp_d = rp_q + PTR_ONE;
      q_d  = mem[rp_q];
    end

    case ({wa, ra})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wp_q] <= data;
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
